mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control FSM for the MIPS core. Sequences the shared 32-bit ALU (alu_32) per instruction class.

---
 rtl/mc_ctrl_fsm.sv | 254 +++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences the shared ALU, memory handshake and write strobes.
// Optional MC_PERF_CNT_EN adds a retired-instruction counter on port instret.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef MC_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [4:0] alu_op,
  output logic       illegal,
`ifdef MC_PERF_CNT_EN
  output logic [CNT_W-1:0] instret,
`endif
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    I_EXEC   = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    TRAP     = 4'd13
  } state_e;

  localparam logic [4:0] ALUOP_NOP  = 5'd0;
  localparam logic [4:0] ALUOP_ADD  = 5'd1;
  localparam logic [4:0] ALUOP_SUBU = 5'd2;
  localparam logic [4:0] ALUOP_SLT  = 5'd3;
  localparam logic [4:0] ALUOP_OR   = 5'd4;
  localparam logic [4:0] ALUOP_SLL  = 5'd5;
  localparam logic [4:0] ALUOP_ADDI = 5'd6;
  localparam logic [4:0] ALUOP_BEQ  = 5'd7;

  localparam int unsigned     WD_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [4:0]      r_alu_q, r_alu_d;
  logic            r_sll_q, r_sll_d;
  logic            is_sw_q, is_sw_d;
  logic            wd_expired;

  // Decode results are latched so later states do not depend on IR staying put.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wd_q    <= '0;
      r_alu_q <= ALUOP_NOP;
      r_sll_q <= 1'b0;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      r_alu_q <= r_alu_d;
      r_sll_q <= r_sll_d;
      is_sw_q <= is_sw_d;
    end
  end

  assign wd_expired = (MEM_TIMEOUT != 0) && (wd_q == WD_LAST);
  assign state_o    = state_q;

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    state_d    = state_q;
    wd_d       = '0;
    r_alu_d    = r_alu_q;
    r_sll_d    = r_sll_q;
    is_sw_d    = is_sw_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    pc_source  = 2'd0;
    alu_op     = ALUOP_NOP;
    illegal    = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (wd_expired) begin
          state_d = TRAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALUOP_ADD;
        case (op)
          6'b000000: begin
            state_d = R_EXEC;
            r_sll_d = 1'b0;
            case (funct)
              6'b100000: r_alu_d = ALUOP_ADD;
              6'b100011: r_alu_d = ALUOP_SUBU;
              6'b101010: r_alu_d = ALUOP_SLT;
              6'b100101: r_alu_d = ALUOP_OR;
              6'b000000: begin
                r_alu_d = ALUOP_SLL;
                r_sll_d = 1'b1;
              end
              default:   state_d = TRAP;
            endcase
          end
          6'b100011: begin
            is_sw_d = 1'b0;
            state_d = MEM_ADDR;
          end
          6'b101011: begin
            is_sw_d = 1'b1;
            state_d = MEM_ADDR;
          end
          6'b001000: state_d = I_EXEC;
          6'b000100: state_d = BRANCH;
          6'b000010: state_d = JUMP;
          default:   state_d = TRAP;
        endcase
      end

      MEM_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        alu_op    = ALUOP_ADD;
        state_d   = is_sw_q ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready)       state_d = MEM_WB;
        else if (wd_expired) state_d = TRAP;
        else                 wd_d    = wd_q + 1'b1;
      end

      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end

      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready)       state_d = FETCH;
        else if (wd_expired) state_d = TRAP;
        else                 wd_d    = wd_q + 1'b1;
      end

      R_EXEC: begin
        alu_src_a = r_sll_q ? 2'd2 : 2'd1;
        alu_op    = r_alu_q;
        state_d   = R_WB;
      end

      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end

      I_EXEC: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        alu_op    = ALUOP_ADDI;
        state_d   = I_WB;
      end

      I_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end

      // pc_write follows the ALU Zero flag within the same cycle.
      BRANCH: begin
        alu_src_a = 2'd1;
        alu_op    = ALUOP_BEQ;
        pc_source = 2'd1;
        pc_write  = zero;
        state_d   = FETCH;
      end

      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        state_d   = FETCH;
      end

      TRAP: illegal = 1'b1;

      default: state_d = TRAP;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (state_d == FETCH &&
                 state_q inside {R_WB, I_WB, MEM_WB, MEM_WR, BRANCH, JUMP}) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle expected outputs are queued with the stimulus
// and compared half a cycle after each active edge.
module tb_mc_ctrl_fsm;

  localparam int unsigned TIMEOUT = 4;

  localparam logic [3:0] ST_IDLE = 4'd0,  ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MADDR = 4'd3,
                         ST_MRD  = 4'd4,  ST_MWB   = 4'd5, ST_MWR    = 4'd6, ST_REXEC = 4'd7,
                         ST_RWB  = 4'd8,  ST_IEXEC = 4'd9, ST_IWB    = 4'd10, ST_BR   = 4'd11,
                         ST_JUMP = 4'd12, ST_TRAP  = 4'd13;

  localparam logic [4:0] A_ADD = 5'd1, A_SUBU = 5'd2, A_SLT = 5'd3, A_OR = 5'd4,
                         A_SLL = 5'd5, A_ADDI = 5'd6, A_BEQ = 5'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
  logic [1:0] alu_src_a, alu_src_b, pc_source;
  logic [4:0] alu_op;
  logic       illegal;
  logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] instret;
`endif

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
    .illegal(illegal),
`ifdef MC_PERF_CNT_EN
    .instret(instret),
`endif
    .state_o(state_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0] src_a, src_b, pc_src;
    logic [4:0] alu_op;
    logic       illegal;
  } outv_t;

  typedef struct {
    logic  rdy;
    logic  z;
    outv_t want;
    string tag;
  } step_t;

  outv_t got;
  assign got = {state_o, mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op, illegal};

  step_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic outv_t o_base(input logic [3:0] st);
    outv_t v;
    v    = '0;
    v.st = st;
    return v;
  endfunction

  function automatic outv_t o_fetch(input logic rdy);
    outv_t v = o_base(ST_FETCH);
    v.mem_req = 1'b1; v.src_b = 2'd1; v.alu_op = A_ADD; v.ir_write = rdy; v.pc_write = rdy;
    return v;
  endfunction

  function automatic outv_t o_decode();
    outv_t v = o_base(ST_DECODE);
    v.src_b = 2'd3; v.alu_op = A_ADD;
    return v;
  endfunction

  function automatic outv_t o_rexec(input logic [1:0] sa, input logic [4:0] aop);
    outv_t v = o_base(ST_REXEC);
    v.src_a = sa; v.alu_op = aop;
    return v;
  endfunction

  function automatic outv_t o_rwb();
    outv_t v = o_base(ST_RWB);
    v.reg_write = 1'b1; v.reg_dst = 1'b1;
    return v;
  endfunction

  function automatic outv_t o_iexec();
    outv_t v = o_base(ST_IEXEC);
    v.src_a = 2'd1; v.src_b = 2'd2; v.alu_op = A_ADDI;
    return v;
  endfunction

  function automatic outv_t o_iwb();
    outv_t v = o_base(ST_IWB);
    v.reg_write = 1'b1;
    return v;
  endfunction

  function automatic outv_t o_maddr();
    outv_t v = o_base(ST_MADDR);
    v.src_a = 2'd1; v.src_b = 2'd2; v.alu_op = A_ADD;
    return v;
  endfunction

  function automatic outv_t o_mrd();
    outv_t v = o_base(ST_MRD);
    v.mem_req = 1'b1; v.i_or_d = 1'b1;
    return v;
  endfunction

  function automatic outv_t o_mwb();
    outv_t v = o_base(ST_MWB);
    v.reg_write = 1'b1; v.mem_to_reg = 1'b1;
    return v;
  endfunction

  function automatic outv_t o_mwr();
    outv_t v = o_base(ST_MWR);
    v.mem_req = 1'b1; v.mem_we = 1'b1; v.i_or_d = 1'b1;
    return v;
  endfunction

  function automatic outv_t o_branch(input logic z);
    outv_t v = o_base(ST_BR);
    v.src_a = 2'd1; v.alu_op = A_BEQ; v.pc_src = 2'd1; v.pc_write = z;
    return v;
  endfunction

  function automatic outv_t o_jump();
    outv_t v = o_base(ST_JUMP);
    v.pc_write = 1'b1; v.pc_src = 2'd2;
    return v;
  endfunction

  function automatic outv_t o_trap();
    outv_t v = o_base(ST_TRAP);
    v.illegal = 1'b1;
    return v;
  endfunction

  task automatic push(input logic rdy, input logic z, input outv_t want, input string tag);
    step_t s;
    s.rdy  = rdy;
    s.z    = z;
    s.want = want;
    s.tag  = tag;
    sb.push_back(s);
  endtask

  // Fetch with a number of unready cycles, then decode (mem_ready high there must be ignored).
  task automatic push_fetch(input int waits, input string tag);
    for (int i = 0; i < waits; i++) push(1'b0, 1'b0, o_fetch(1'b0), {tag, "_fetch_wait"});
    push(1'b1, 1'b0, o_fetch(1'b1), {tag, "_fetch"});
    push(1'b1, 1'b0, o_decode(), {tag, "_decode"});
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      step_t s;
      s = sb.pop_front();
      @(negedge clk);
      mem_ready = s.rdy;
      zero      = s.z;
      #1;
      check(s.tag, {8'h0, got}, {8'h0, s.want});
    end
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    mem_ready = 1'b0;
    #1;
    check(tag, {8'h0, got}, {8'h0, o_base(ST_IDLE)});
`ifdef MC_PERF_CNT_EN
    check({tag, "_instret"}, instret, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(1'b1, 1'b0, o_base(ST_IDLE), {tag, "_idle"});
    drain();
  endtask

  task automatic r_instr(input logic [5:0] f, input logic [1:0] sa, input logic [4:0] aop,
                         input string tag);
    op = 6'b000000; funct = f;
    push_fetch(0, tag);
    push(1'b1, 1'b0, o_rexec(sa, aop), {tag, "_exec"});
    push(1'b1, 1'b0, o_rwb(), {tag, "_wb"});
    drain();
  endtask

  initial begin
    rst = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    do_reset("reset");

    r_instr(6'b100000, 2'd1, A_ADD, "add");

    op = 6'b101011;
    push_fetch(0, "sw");
    push(1'b1, 1'b0, o_maddr(), "sw_addr");
    push(1'b0, 1'b0, o_mwr(), "sw_wr_wait");
    push(1'b1, 1'b0, o_mwr(), "sw_wr");
    drain();

    op = 6'b000010;
    push_fetch(0, "j");
    push(1'b1, 1'b0, o_jump(), "j_jump");
    drain();
`ifdef MC_PERF_CNT_EN
    @(posedge clk);
    #1 check("instret_3", instret, 32'd3);
`endif

    r_instr(6'b000000, 2'd2, A_SLL,  "sll");
    r_instr(6'b100011, 2'd1, A_SUBU, "subu");
    r_instr(6'b101010, 2'd1, A_SLT,  "slt");
    r_instr(6'b100101, 2'd1, A_OR,   "or");

    op = 6'b001000;
    push_fetch(0, "addi");
    push(1'b1, 1'b0, o_iexec(), "addi_exec");
    push(1'b1, 1'b0, o_iwb(), "addi_wb");
    drain();

    // lw with three unready cycles: request and address select must stay put.
    op = 6'b100011;
    push_fetch(0, "lw");
    push(1'b1, 1'b0, o_maddr(), "lw_addr");
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, o_mrd(), "lw_rd_wait");
    push(1'b1, 1'b0, o_mrd(), "lw_rd");
    push(1'b1, 1'b0, o_mwb(), "lw_wb");
    drain();

    op = 6'b000100;
    push_fetch(2, "beq_t");
    push(1'b1, 1'b1, o_branch(1'b1), "beq_taken");
    push_fetch(0, "beq_nt");
    push(1'b1, 1'b0, o_branch(1'b0), "beq_not_taken");
    push(1'b1, 1'b0, o_fetch(1'b1), "after_beq_fetch");
    push(1'b1, 1'b0, o_decode(), "after_beq_decode");
    push(1'b1, 1'b1, o_branch(1'b1), "beq_taken2");
    drain();

    // Abort a store mid-handshake: reset must drop every strobe immediately.
    op = 6'b101011;
    push_fetch(0, "sw_abort");
    push(1'b1, 1'b0, o_maddr(), "sw_abort_addr");
    push(1'b0, 1'b0, o_mwr(), "sw_abort_wait");
    push(1'b0, 1'b0, o_mwr(), "sw_abort_wait");
    drain();
    do_reset("rst_mid_wr");

    op = 6'b111111;
    push_fetch(0, "bad_op");
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, o_trap(), "bad_op_trap");
    drain();

    do_reset("rst_after_trap");
    for (int i = 0; i < int'(TIMEOUT); i++) push(1'b0, 1'b0, o_fetch(1'b0), "wd_wait");
    push(1'b1, 1'b0, o_trap(), "wd_trap");
    push(1'b1, 1'b0, o_trap(), "wd_trap_hold");
    drain();

    do_reset("rst_after_wd");
    op = 6'b000000; funct = 6'b000001;
    push_fetch(0, "bad_funct");
    push(1'b1, 1'b0, o_trap(), "bad_funct_trap");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
